sobel_window_gen: RTL and testbench

- Producer side of the Sobel core's 3x3 pixel-window interface.
- Accepts a raster-order grayscale pixel stream, one pixel per handshake, and emits one zero-padded 3x3 neighbourhood per image pixel in raster order.
- Outputs p0..p8 connect directly to the window inputs of the sobel core. This replaces the file-driven window feed used in simulation.

---
 rtl/sobel_window_gen_if.sv | 30 +++
 rtl/sobel_window_gen.sv | 182 ++++++++++++++++++
 tb/tb_sobel_window_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle for the Sobel window generator.
// Both streams use the same handshake: a transfer happens on a rising clk edge where
// valid & ready are both high; once valid is high, the payload stays stable until it transfers.
interface sobel_window_gen_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;

  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [PIX_W-1:0] p0, p1, p2;
  logic [PIX_W-1:0] p3, p4, p5;
  logic [PIX_W-1:0] p6, p7, p8;

  // master: the window generator; slave: the pixel source / window consumer
  modport master (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_last,
    output p0, p1, p2, p3, p4, p5, p6, p7, p8
  );

  modport slave (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_last,
    input  p0, p1, p2, p3, p4, p5, p6, p7, p8
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Turns a raster pixel stream into one zero-padded 3x3 neighbourhood per pixel.
// Two line buffers plus a two-column shift window supply the neighbourhood of the pixel one row and one column behind the input.
module sobel_window_gen #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int PIX_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sobel_window_gen_if.master  bus,
  output logic [1:0]          dbg_state
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       state;
  logic [XW-1:0]    xi;          // column of the next pixel to enter (virtual in FLUSH)
  logic [YW-1:0]    yi;
  logic [XW-1:0]    cx;          // centre of the next window to be loaded
  logic [YW-1:0]    cy;

  logic [PIX_W-1:0] lb0 [IMG_W]; // row yi-2 at column x
  logic [PIX_W-1:0] lb1 [IMG_W]; // row yi-1 at column x

  // Two older columns of the neighbourhood: top/middle/bottom rows
  logic [PIX_W-1:0] c0_t, c0_m, c0_b;
  logic [PIX_W-1:0] c1_t, c1_m, c1_b;

  logic [PIX_W-1:0] n_t, n_m, n_b;
  logic             in_xfer, out_xfer, out_free;
  logic             step, load;
  logic             top_ok, bot_ok, left_ok, right_ok;
  logic             centre_last;
  logic             in_ready_c;

  assign dbg_state = state;

  assign out_free = !bus.out_valid || bus.out_ready;
  assign in_xfer  = bus.in_valid && in_ready_c;
  assign out_xfer = bus.out_valid && bus.out_ready;

  // A frame only starts once the previous frame's final window has left the output register.
  always_comb begin
    in_ready_c = 1'b0;
    case (state)
      ST_FILL: in_ready_c = !bus.out_valid;
      ST_RUN:  in_ready_c = out_free;
      default: in_ready_c = 1'b0;
    endcase
  end

  assign bus.in_ready = in_ready_c;

  // FLUSH advances through virtual pixels below the image, one per free output slot.
  assign step = ((state != ST_FLUSH) && in_xfer) || ((state == ST_FLUSH) && out_free);
  assign load = ((state == ST_RUN) && in_xfer) || ((state == ST_FLUSH) && out_free);

  assign n_t = lb0[xi];
  assign n_m = lb1[xi];
  assign n_b = (state == ST_FLUSH) ? '0 : bus.in_pixel;

  assign top_ok      = (cy != '0);
  assign bot_ok      = (cy != Y_MAX);
  assign left_ok     = (cx != '0);
  assign right_ok    = (cx != X_MAX);
  assign centre_last = (cx == X_MAX) && (cy == Y_MAX);

  always_ff @(posedge clk) begin
    if (step) begin
      lb0[xi] <= lb1[xi];
      lb1[xi] <= n_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
      xi    <= '0;
      yi    <= '0;
      cx    <= '0;
      cy    <= '0;
      c0_t  <= '0;
      c0_m  <= '0;
      c0_b  <= '0;
      c1_t  <= '0;
      c1_m  <= '0;
      c1_b  <= '0;
    end else begin
      if (step) begin
        c0_t <= c1_t;
        c0_m <= c1_m;
        c0_b <= c1_b;
        c1_t <= n_t;
        c1_m <= n_m;
        c1_b <= n_b;
        if ((state == ST_FLUSH) && centre_last) begin
          xi <= '0;
          yi <= '0;
        end else if (xi == X_MAX) begin
          xi <= '0;
          yi <= (yi == Y_MAX) ? '0 : yi + YW'(1);
        end else begin
          xi <= xi + XW'(1);
        end
      end

      if (load) begin
        if (cx == X_MAX) begin
          cx <= '0;
          cy <= (cy == Y_MAX) ? '0 : cy + YW'(1);
        end else begin
          cx <= cx + XW'(1);
        end
      end

      case (state)
        ST_FILL: begin
          // Pixel (0,1) completes the first neighbourhood except its right column.
          if (in_xfer && (xi == '0) && (yi == Y_ONE)) state <= ST_RUN;
        end
        ST_RUN: begin
          if (in_xfer && (xi == X_MAX) && (yi == Y_MAX)) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (load && centre_last) state <= ST_FILL;
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.p0 <= '0;
      bus.p1 <= '0;
      bus.p2 <= '0;
      bus.p3 <= '0;
      bus.p4 <= '0;
      bus.p5 <= '0;
      bus.p6 <= '0;
      bus.p7 <= '0;
      bus.p8 <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_last  <= centre_last;
      bus.p0 <= (top_ok && left_ok)  ? c0_t : '0;
      bus.p1 <= top_ok               ? c1_t : '0;
      bus.p2 <= (top_ok && right_ok) ? n_t  : '0;
      bus.p3 <= left_ok              ? c0_m : '0;
      bus.p4 <= c1_m;
      bus.p5 <= right_ok             ? n_m  : '0;
      bus.p6 <= (bot_ok && left_ok)  ? c0_b : '0;
      bus.p7 <= bot_ok               ? c1_b : '0;
      bus.p8 <= (bot_ok && right_ok) ? n_b  : '0;
    end else if (out_xfer) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end
  end

  logic [9*PIX_W:0] win_q;
  assign win_q = {bus.out_last, bus.p0, bus.p1, bus.p2, bus.p3, bus.p4,
                  bus.p5, bus.p6, bus.p7, bus.p8};

  a_last_with_valid: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_last |-> bus.out_valid);

  a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(win_q)));

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x3 image: fixed frames, a stall,
// a mid-frame reset and back-to-back jittered frames against a zero-padded window model.
module tb_sobel_window_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int PW   = 8;
  localparam int NPIX = W * H;
  localparam int WW   = 9 * PW + 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  sobel_window_gen_if #(.PIX_W(PW)) bus ();

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [PW-1:0] img [NPIX];

  function automatic logic [PW-1:0] px(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return '0;
    return img[y*W + x];
  endfunction

  function automatic logic [WW-1:0] model_win(input int cx, input int cy);
    logic last;
    last = (cx == W-1) && (cy == H-1);
    return {last, px(cx-1, cy-1), px(cx, cy-1), px(cx+1, cy-1),
                  px(cx-1, cy),   px(cx, cy),   px(cx+1, cy),
                  px(cx-1, cy+1), px(cx, cy+1), px(cx+1, cy+1)};
  endfunction

  function automatic logic [WW-1:0] win(input logic l, input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    return {l, PW'(a0), PW'(a1), PW'(a2), PW'(a3), PW'(a4), PW'(a5), PW'(a6), PW'(a7), PW'(a8)};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] cap[$];
  int            last_cnt = 0;
  bit            mon_en = 1'b0;
  logic [WW-1:0] obs;

  assign obs = {bus.out_last, bus.p0, bus.p1, bus.p2, bus.p3, bus.p4,
                bus.p5, bus.p6, bus.p7, bus.p8};

  always @(negedge clk) begin
    if (mon_en && rst_n && bus.out_valid && bus.out_ready) begin
      cap.push_back(obs);
      if (bus.out_last) last_cnt++;
      if (exp_q.size() == 0) check("extra_win", WW'(exp_q.size()), WW'(1));
      else                   check("win", obs, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  int acc6_cyc;
  int first_valid_cyc;

  task automatic run_frame(input int stall_start, input bit jitter);
    int            idx;
    int            cyc;
    bit            acc;
    bit            stalled;
    logic [WW-1:0] snap;
    idx = 0;
    cyc = 0;
    snap = '0;
    cap.delete();
    last_cnt = 0;
    acc6_cyc = -1;
    first_valid_cyc = -1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back(model_win(x, y));
    while (cap.size() < NPIX && cyc < 400) begin
      stalled = (cyc >= stall_start) && (cyc < stall_start + 10);
      bus.in_valid  = (idx < NPIX) && (!jitter || $urandom_range(0, 3) != 0);
      bus.in_pixel  = (idx < NPIX) ? img[idx] : '0;
      bus.out_ready = !stalled && (!jitter || $urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stalled) begin
        if (cyc == stall_start) snap = obs;
        check("stall_in_ready", WW'(bus.in_ready), WW'(0));
        check("stall_valid", WW'(bus.out_valid), WW'(1));
        if (cyc > stall_start) check("stall_hold", obs, snap);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx == W + 2) acc6_cyc = cyc;
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("frame_windows", WW'(cap.size()), WW'(NPIX));
    check("frame_last_cnt", WW'(last_cnt), WW'(1));
    check("frame_pixels", WW'(idx), WW'(NPIX));
    check("exp_q_drained", WW'(exp_q.size()), WW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    int cyc;
    bit acc;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", WW'(bus.out_valid), WW'(0));
    check("rst_out_last", WW'(bus.out_last), WW'(0));
    check("rst_window", obs, WW'(0));
    check("rst_in_ready", WW'(bus.in_ready), WW'(1));
    check("rst_state", WW'(dbg_state), WW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Frame A: pixels 1..12, continuous stream, consumer always ready
    for (int i = 0; i < NPIX; i++) img[i] = PW'(i + 1);
    run_frame(-100, 1'b0);
    check("first_valid_latency", WW'(first_valid_cyc), WW'(acc6_cyc + 1));
    check("win_first", cap[0], win(1'b0, 0, 0, 0, 0, 1, 2, 0, 5, 6));
    check("win_centre_1_1", cap[5], win(1'b0, 1, 2, 3, 5, 6, 7, 9, 10, 11));
    check("win_last", cap[11], win(1'b1, 7, 8, 0, 11, 12, 0, 0, 0, 0));
    check("state_after_frame", WW'(dbg_state), WW'(0));

    // Frame B: random pixels, consumer stalls 10 cycles mid-RUN
    for (int i = 0; i < NPIX; i++) img[i] = PW'($urandom_range(0, 255));
    run_frame(7, 1'b0);

    // Mid-frame reset after 7 pixels
    mon_en = 1'b0;
    for (int i = 0; i < NPIX; i++) img[i] = PW'(i + 100);
    idx = 0;
    cyc = 0;
    bus.out_ready = 1'b1;
    while (idx < 7 && cyc < 50) begin
      bus.in_valid = 1'b1;
      bus.in_pixel = img[idx];
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("pre_rst_pixels", WW'(idx), WW'(7));
    check("pre_rst_valid", WW'(bus.out_valid), WW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", WW'(bus.out_valid), WW'(0));
    check("async_rst_last", WW'(bus.out_last), WW'(0));
    check("async_rst_window", obs, WW'(0));
    check("async_rst_state", WW'(dbg_state), WW'(0));
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Fresh frame after reset: 21..32
    for (int i = 0; i < NPIX; i++) img[i] = PW'(i + 21);
    run_frame(-100, 1'b0);
    check("post_rst_latency", WW'(first_valid_cyc), WW'(acc6_cyc + 1));
    check("post_rst_first_win", cap[0], win(1'b0, 0, 0, 0, 0, 21, 22, 0, 25, 26));

    // Two back-to-back frames with random valid/ready gaps
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = PW'($urandom_range(0, 255));
      run_frame(-100, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
